// File: rtl/sm_key_debounce.sv
// Push-button conditioner: per-key 2-FF sync, debounce, and press/release/auto-repeat pulses.
// One channel instance per key; channels share nothing but clk/rst.

module sm_key_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic p_in,
  output logic down,
  output logic pressed,
  output logic released,
  output logic rep
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_TC = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_TC = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RP_TC = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RPT} state_t;

  logic          s1_q, s1_d, s2_q, s2_d;
  logic          down_q, down_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          pressed_q, pressed_d, released_q, released_d, rep_q, rep_d;
  state_t        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          mismatch, accept;

  always_comb begin
    s1_d       = p_in;
    s2_d       = s1_q;
    mismatch   = (s2_q != down_q);
    accept     = mismatch && (db_cnt_q == DB_TC);
    // any matching cycle throws away the partial count
    db_cnt_d   = (!mismatch || accept) ? '0 : db_cnt_q + 1'b1;
    down_d     = down_q ^ accept;
    pressed_d  = accept & ~down_q;
    released_d = accept & down_q;

    state_d = state_q;
    rcnt_d  = rcnt_q;
    rep_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed_d && (REPEAT_DELAY != 0)) begin
          state_d = DELAY;
          rcnt_d  = '0;
        end
      end
      DELAY: begin
        if (released_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == RD_TC) begin
          state_d = RPT;
          rep_d   = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d  = rcnt_q + 1'b1;
        end
      end
      RPT: begin
        // release beats a repeat tick landing on the same edge
        if (released_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == RP_TC) begin
          rep_d   = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d  = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      down_q     <= 1'b0;
      db_cnt_q   <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      rep_q      <= 1'b0;
      state_q    <= IDLE;
      rcnt_q     <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      down_q     <= down_d;
      db_cnt_q   <= db_cnt_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      rep_q      <= rep_d;
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign down     = down_q;
  assign pressed  = pressed_q;
  assign released = released_q;
  assign rep      = rep_q;
endmodule

module sm_key_debounce #(
  parameter int KEYS            = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KEYS-1:0] key_raw,
  output logic [KEYS-1:0] key_down,
  output logic [KEYS-1:0] key_pressed,
  output logic [KEYS-1:0] key_released,
  output logic [KEYS-1:0] key_repeat,
  output logic [KEYS-1:0] key_event
);
  logic [KEYS-1:0] p;

  assign p = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

  for (genvar k = 0; k < KEYS; k++) begin : g_ch
    sm_key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .p_in    (p[k]),
      .down    (key_down[k]),
      .pressed (key_pressed[k]),
      .released(key_released[k]),
      .rep     (key_repeat[k])
    );
  end

  assign key_event = key_pressed | key_repeat;
endmodule
